// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples sclk/cs/mosi in the clk domain, assembles an
// LSB-first word on dout with a done strobe, and shifts a preloaded reply on miso.
module spi_slave_rx #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_hist, cs_hist;
  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic [DATA_WIDTH-1:0]   tx_shift, tx_shift_next;
  logic [DATA_WIDTH-1:0]   rx_shift, rx_shift_next;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   dout_next;
  logic                    done_next, err_next, miso_next;

  // Synchronizer chains plus one history flop for edge detection; cs idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign cs_fall   = ~cs_s & cs_hist;
  assign cs_rise   = cs_s & ~cs_hist;

  // Reply buffer: may be reloaded at any time without disturbing the active frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_buf <= '0;
    end else if (tx_load) begin
      tx_buf <= tx_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      dout      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
    end else begin
      state     <= state_next;
      tx_shift  <= tx_shift_next;
      rx_shift  <= rx_shift_next;
      bit_cnt   <= bit_cnt_next;
      dout      <= dout_next;
      done      <= done_next;
      frame_err <= err_next;
      miso      <= miso_next;
    end
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_next    = state;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    bit_cnt_next  = bit_cnt;
    dout_next     = dout;
    done_next     = 1'b0;
    err_next      = 1'b0;
    miso_next     = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          // A reload coinciding with the frame start is forwarded straight in.
          tx_shift_next = tx_load ? tx_data : tx_buf;
          rx_shift_next = '0;
          bit_cnt_next  = '0;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        miso_next = tx_shift[0];
        if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
          // Word complete: publish it; a simultaneous cs rise ends the frame cleanly.
          dout_next  = rx_shift;
          done_next  = 1'b1;
          state_next = cs_rise ? IDLE : WAIT_CS;
        end else if (cs_rise) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_next = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
            bit_cnt_next  = bit_cnt + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_shift_next = tx_shift >> 1;
          end
        end
      end

      WAIT_CS: begin
        if (cs_rise) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Full-duplex SPI responder: the slave-side counterpart to `spi_master`. It oversamples the master's `sclk`, `cs` and `mosi` in the system clock domain and assembles a 12-bit word, presenting it on `dout` with a one-cycle `done` strobe. In the same frame it shifts a preloaded reply word out on `miso`. It sits behind `spi_master` in the SPI subsystem and replaces the receive-only path for loopback and register-read use.

## Interface
- `DATA_WIDTH`, 12: frame length in bits; also the `dout`/`tx_data` width.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `cs`, `mosi`; must be ≥ 2.
- `clk` in 1: system clock. All logic is on the rising edge. One clock only.
- `reset` in 1: asynchronous, active-low reset. Assertion is immediate; deassertion is sampled on `clk`.
- `sclk` in 1: SPI clock from the master, asynchronous to `clk`.
- `cs` in 1: chip select, active-low, asynchronous.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master.
- `tx_data` in DATA_WIDTH: reply word.
- `tx_load` in 1: one-cycle strobe that captures `tx_data` into the reply buffer.
- `dout` out DATA_WIDTH: last complete received word.
- `done` out 1: one-cycle pulse when `dout` updates.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), LSB first in both directions.
- `mosi` is sampled on the `sclk` rising edge. `miso` changes after the `sclk` falling edge.
- Each input passes through SYNC_STAGES flops, then one history flop. Edges are detected in the `clk` domain: `cs` fall/rise and `sclk` rise/fall.
- `tx_buf` (DATA_WIDTH bits) loads from `tx_data` on any cycle where `tx_load`=1, in any state. The current frame's transmit shifter is not affected.
- FSM states are IDLE, SHIFT and WAIT_CS.
- IDLE:
  - `miso`=0.
  - On `cs` fall: `tx_shift`←`tx_buf`, `bit_cnt`←0, `rx_shift`←0, go to SHIFT.
  - If `tx_load` and the `cs` fall happen in the same cycle, `tx_shift` takes the new `tx_data` (bypass).
- SHIFT:
  - `miso`=`tx_shift[0]`.
  - On `sclk` rise: `rx_shift`←{`mosi_s`, `rx_shift[W-1:1]`} and `bit_cnt`++.
  - On `sclk` fall: `tx_shift`←`tx_shift`>>1.
  - When the rise that makes `bit_cnt`=DATA_WIDTH is processed, the next cycle has `dout`←assembled word and `done`=1. Then go to WAIT_CS.
  - On `cs` rise with `bit_cnt`<DATA_WIDTH: `frame_err`=1 for one cycle, `dout` is unchanged, go to IDLE.
- WAIT_CS:
  - `miso`=0.
  - All `sclk` edges are ignored.
  - On `cs` rise go to IDLE. `frame_err` is not raised.
- `bit_cnt` is ⌈log2(DATA_WIDTH+1)⌉ bits and never wraps, because the FSM exits before overflow.
- A `cs` fall while in SHIFT or WAIT_CS cannot occur without a prior rise, so it needs no handling.
- `sclk` edges while in IDLE are ignored.

## Timing
- Reset values: `miso`=0, `dout`=0, `done`=0, `frame_err`=0, state=IDLE, `tx_buf`=0, all synchronizer flops=0 except `cs` sync flops=1.
- Input constraint: `sclk` high and low phases are each ≥ SYNC_STAGES+2 `clk` periods. `mosi` is stable from ≥1 `clk` before the `sclk` rise until ≥1 `clk` after it.
- Edge-detect latency: an input edge is seen SYNC_STAGES+1 `clk` rising edges after it arrives.
- `done` latency: `done` asserts SYNC_STAGES+2 cycles after the 12th `sclk` rise.
- `miso` latency: `miso` updates SYNC_STAGES+2 cycles after an `sclk` fall or `cs` fall.
- `done` and `frame_err` are never both high, and each is exactly one cycle wide.
- Reset mid-frame: all state clears immediately. The next frame is recognized only after a fresh `cs` fall.

## Test plan
- Basic receive: reset low 2 cycles then high; master sends `din`=12'd791 (0x317) with `sclk`=clk/20 → exactly one `done` pulse, `dout`=0x317, `frame_err` never high.
- Full-duplex reply:
  - Stimulus: `tx_load` with `tx_data`=0xA5C before the frame, master sends 0x0F0.
  - Required: master-side capture of `miso` equals 0xA5C (LSB first, bit 0 present before the first `sclk` rise), and `dout`=0x0F0.
- Aborted frame: `cs` rises after 7 `sclk` rises → one `frame_err` pulse, no `done`, `dout` keeps the prior 0x317. A following full frame of 0x001 gives `done` and `dout`=0x001.
- Back-to-back frames:
  - Stimulus: frames 0xFFF then 0x000, with `tx_load` of 0x123 during frame 1 (`tx_buf` was 0x456).
  - Required: frame 1 `miso`=0x456, frame 2 `miso`=0x123, two `done` pulses with `dout`=0xFFF then 0x000.
- Extra clocks: 14 `sclk` pulses in one `cs`-low window with data 0x555 → a single `done` after the 12th rise, `dout`=0x555, extra edges ignored, no `frame_err` on `cs` rise.
- Reset mid-frame: `reset` asserted after 5 bits → `dout`=0, `miso`=0 immediately. After release, the next full frame 0x2AA is received correctly.
